// File: rtl/shift_cmd_queue_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : shift_cmd_queue_if
// Description : Handshake and shifter-side signal bundle for shift_cmd_queue.
//               The slave modport is the queue itself. The master modport is
//               the environment: the command producer, the shifter and the
//               result consumer.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
interface shift_cmd_queue_if #(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_data;
  logic [2:0]       cmd_amt;
  logic             cmd_dir;
  logic [3:0]       sh_data_in;
  logic [2:0]       sh_shift_amt;
  logic             sh_direction;
  logic [3:0]       sh_data_out;
  logic             res_valid;
  logic             res_ready;
  logic [3:0]       res_data;
  logic             res_ovf;
  logic [LVL_W-1:0] fifo_level;
  logic [7:0]       op_count;

  modport slave (
    input  cmd_valid, cmd_data, cmd_amt, cmd_dir, sh_data_out, res_ready,
    output cmd_ready, sh_data_in, sh_shift_amt, sh_direction,
           res_valid, res_data, res_ovf, fifo_level, op_count
  );

  modport master (
    output cmd_valid, cmd_data, cmd_amt, cmd_dir, sh_data_out, res_ready,
    input  cmd_ready, sh_data_in, sh_shift_amt, sh_direction,
           res_valid, res_data, res_ovf, fifo_level, op_count
  );
endinterface
`default_nettype wire

// File: rtl/shift_cmd_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : shift_cmd_queue
// Description : Command FIFO ahead of a combinational 4-bit barrel shifter.
//               The head command drives the shifter. The shifter output is
//               captured into a result register that has its own valid/ready
//               handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module shift_cmd_queue #(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  shift_cmd_queue_if.slave  bus
);

  localparam int               c_PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] c_FULL  = LVL_W'(DEPTH);

  // Each entry is {data[3:0], amt[2:0], dir}.
  logic [7:0]         r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [LVL_W-1:0]   r_level;
  logic               r_res_valid;
  logic [3:0]         r_res_data;
  logic               r_res_ovf;
  logic [7:0]         r_op_count;

  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [7:0]         w_head;

  // cmd_ready comes from the level only. A full queue therefore refuses a push
  // even in a cycle where it also pops, and res_ready has no path to cmd_ready.
  assign bus.cmd_ready = (r_level < c_FULL);
  assign w_empty       = (r_level == '0);
  assign w_push        = bus.cmd_valid & bus.cmd_ready;
  assign w_pop         = ~w_empty & (~r_res_valid | bus.res_ready);
  assign w_head        = r_mem[r_rptr];

  // The shifter inputs are forced to zero while the queue is empty, so stale
  // storage contents never reach the shifter.
  assign bus.sh_data_in   = w_empty ? 4'd0 : w_head[7:4];
  assign bus.sh_shift_amt = w_empty ? 3'd0 : w_head[3:1];
  assign bus.sh_direction = w_empty ? 1'b0 : w_head[0];

  assign bus.res_valid  = r_res_valid;
  assign bus.res_data   = r_res_data;
  assign bus.res_ovf    = r_res_ovf;
  assign bus.fifo_level = r_level;
  assign bus.op_count   = r_op_count;

  // Storage array. It needs no reset because the level qualifies every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {bus.cmd_data, bus.cmd_amt, bus.cmd_dir};
    end
  end

  // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Result register: capture on pop, release when the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_data  <= 4'd0;
      r_res_ovf   <= 1'b0;
      r_op_count  <= 8'd0;
    end else if (w_pop) begin
      r_res_valid <= 1'b1;
      r_res_data  <= bus.sh_data_out;
      r_res_ovf   <= w_head[3];
      r_op_count  <= r_op_count + 8'd1;
    end else if (r_res_valid && bus.res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
